// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one subtract/restore step per cycle.
// A start pulse in IDLE or DONE captures the dividend and divisor. N steps follow,
// and then quotient, remainder and div_zero are held in DONE until the next start.
// Optional macro SEQ_DIVIDER_SIGNED_EN adds an is_signed input for
// two's-complement operands.
module seq_divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic         is_signed,
`endif
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         busy,
   output logic         done,
   output logic         div_zero
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state;
   logic [N-1:0] rem;
   logic [N-1:0] dvd;
   logic [N-1:0] dsr;
   logic [CW-1:0] cnt;

   logic [N:0]   shifted;
   logic [N-1:0] diff;
   logic         dtop;
   logic         cout;
   logic         take;
   logic [N-1:0] rem_nx;
   logic [N-1:0] quo_nx;
   logic [N-1:0] q_fix;
   logic [N-1:0] r_fix;
   logic [N-1:0] a_mag;
   logic [N-1:0] b_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q;
   logic neg_r;
   logic sd;
   logic sv;
`endif

   // One restoring step. The trial is an (N+1)-bit subtract done as a + ~b + 1.
   // dtop is always 0 when there is no borrow, so the take term equals carry-out.
   always_comb begin
      shifted = {rem, dvd[N-1]};
      {cout, dtop, diff} = {1'b0, shifted} + {1'b0, 1'b1, ~dsr} + (N+2)'(1);
      take    = cout & ~dtop;
      rem_nx  = take ? diff : shifted[N-1:0];
      quo_nx  = {dvd[N-2:0], take};
   end

   // Operand magnitudes at capture, and the sign fix-up applied on entry to DONE.
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sd    = is_signed & dividend[N-1];
      sv    = is_signed & divisor[N-1];
      a_mag = sd ? -dividend : dividend;
      b_mag = sv ? -divisor : divisor;
      q_fix = neg_q ? -quo_nx : quo_nx;
      r_fix = neg_r ? -rem_nx : rem_nx;
`else
      a_mag = dividend;
      b_mag = divisor;
      q_fix = quo_nx;
      r_fix = rem_nx;
`endif
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dvd <= a_mag;
                  dsr <= b_mag;
                  rem <= '0;
                  cnt <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  neg_q <= sd ^ sv;
                  neg_r <= sd;
`endif
                  if (divisor == '0) begin
                     state     <= DONE;
                     quotient  <= '1;
                     remainder <= dividend;
                     div_zero  <= 1'b1;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state    <= BUSY;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     div_zero <= 1'b0;
                  end
               end
            end
            BUSY: begin
               rem <= rem_nx;
               dvd <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quotient  <= q_fix;
                  remainder <= r_fix;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: vector table, hand-written corner sequences and randomized
// operations checked against an arithmetic reference model.
module tb_seq_divider;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         sgn;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_zero;

   always #5 clk = ~clk;

   seq_divider #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .is_signed (sgn),
`endif
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      bit           s;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
   } vec_t;

   vec_t vt[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division; SV int division truncates toward zero,
   // so the remainder naturally takes the sign of the dividend.
   function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input bit s,
                                 output logic [N-1:0] q, output logic [N-1:0] r,
                                 output logic dz);
      int sa;
      int sb;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (s) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = N'(sa / sb);
         r  = N'(sa % sb);
         dz = 1'b0;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for done with a bounded budget; returns edges seen after the accept edge.
   task automatic wait_done(input int already, input string tag, output int cycles);
      bit busy_ok;
      busy_ok = 1'b1;
      cycles  = already;
      while (!done && cycles < 3 * N) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         cycles++;
      end
      chk({tag, " latency"}, cycles, N);
      chk({tag, " busy_held"}, {31'd0, busy_ok}, 1);
      chk({tag, " busy_end"}, {31'd0, busy}, 0);
   endtask

   task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input bit s,
                      input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                      input string tag);
      int cyc;
      dividend = a;
      divisor  = b;
      sgn      = s;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = N'($urandom);
      divisor  = N'($urandom);
      sgn      = 1'($urandom);
      if (b == '0) begin
         chk({tag, " dz_done"}, {31'd0, done}, 1);
         chk({tag, " dz_busy"}, {31'd0, busy}, 0);
      end else begin
         chk({tag, " busy_start"}, {31'd0, busy}, 1);
         chk({tag, " done_low"}, {31'd0, done}, 0);
         wait_done(0, tag, cyc);
      end
      chk({tag, " q"}, quotient, eq);
      chk({tag, " r"}, remainder, er);
      chk({tag, " dz"}, {31'd0, div_zero}, {31'd0, edz});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] ra, rb, rq, rr;
      logic         rdz;
      bit           rs;
      int           cyc;

      vt.push_back('{a:8'd100, b:8'd7,   s:0, q:8'd14,  r:8'd2,  dz:1'b0});
      vt.push_back('{a:8'd255, b:8'd1,   s:0, q:8'd255, r:8'd0,  dz:1'b0});
      vt.push_back('{a:8'd3,   b:8'd200, s:0, q:8'd0,   r:8'd3,  dz:1'b0});
      vt.push_back('{a:8'd5,   b:8'd0,   s:0, q:8'hFF,  r:8'd5,  dz:1'b1});
      vt.push_back('{a:8'd0,   b:8'd5,   s:0, q:8'd0,   r:8'd0,  dz:1'b0});
      vt.push_back('{a:8'd255, b:8'd255, s:0, q:8'd1,   r:8'd0,  dz:1'b0});
      vt.push_back('{a:8'd128, b:8'd3,   s:0, q:8'd42,  r:8'd2,  dz:1'b0});
      vt.push_back('{a:8'd7,   b:8'd8,   s:0, q:8'd0,   r:8'd7,  dz:1'b0});
      vt.push_back('{a:8'hF9,  b:8'd2,   s:0, q:8'h7C,  r:8'd1,  dz:1'b0});
`ifdef SEQ_DIVIDER_SIGNED_EN
      vt.push_back('{a:8'hF9,  b:8'd2,   s:1, q:8'hFD,  r:8'hFF, dz:1'b0});
      vt.push_back('{a:8'h80,  b:8'hFF,  s:1, q:8'h80,  r:8'h00, dz:1'b0});
      vt.push_back('{a:8'h07,  b:8'hFE,  s:1, q:8'hFD,  r:8'h01, dz:1'b0});
      vt.push_back('{a:8'hF9,  b:8'h00,  s:1, q:8'hFF,  r:8'hF9, dz:1'b1});
`endif

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; sgn = 1'b0;
      tick(); tick();
      chk("reset q", quotient, 0);
      chk("reset r", remainder, 0);
      chk("reset busy", {31'd0, busy}, 0);
      chk("reset done", {31'd0, done}, 0);
      chk("reset dz", {31'd0, div_zero}, 0);
      rst = 1'b0;
      tick();

      // Table: each operation starts straight from DONE of the previous one.
      foreach (vt[i])
         run(vt[i].a, vt[i].b, vt[i].s, vt[i].q, vt[i].r, vt[i].dz, $sformatf("vec%0d", i));

      // Results hold while idle in DONE.
      repeat (4) tick();
      chk("hold done", {31'd0, done}, 1);
      chk("hold q", quotient, vt[vt.size()-1].q);
      chk("hold r", remainder, vt[vt.size()-1].r);

      // Start during BUSY is ignored.
      dividend = 8'd100; divisor = 8'd7; sgn = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      dividend = 8'd9; divisor = 8'd3; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(3, "ignore", cyc);
      chk("ignore q", quotient, 14);
      chk("ignore r", remainder, 2);

      // Asynchronous reset mid-operation.
      dividend = 8'd100; divisor = 8'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("arst q", quotient, 0);
      chk("arst r", remainder, 0);
      chk("arst busy", {31'd0, busy}, 0);
      chk("arst done", {31'd0, done}, 0);
      #2;
      rst = 1'b0;
      tick();
      chk("arst idle done", {31'd0, done}, 0);
      run(8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, "post_rst");

      // Randomized operations against the reference model.
      for (int k = 0; k < 300; k++) begin
         ra = N'($urandom);
         case ($urandom_range(0, 9))
            0:       rb = '0;
            1, 2, 3: rb = N'($urandom_range(1, 15));
            default: rb = N'($urandom);
         endcase
`ifdef SEQ_DIVIDER_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         model(ra, rb, rs, rq, rr, rdz);
         run(ra, rb, rs, rq, rr, rdz, $sformatf("rnd%0d a=%0h b=%0h s=%0d", k, ra, rb, rs));
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
